// File: rtl/fifo_ctl_16_4_pkg.sv
// Shared sizes and state payload for the 16x4 FIFO controller.
package fifo_ctl_16_4_pkg;

  localparam int unsigned FIFO_DEPTH      = 16;
  localparam int unsigned FIFO_WIDTH      = 4;
  localparam int unsigned FIFO_PTR_BITS   = 4;
  localparam int unsigned FIFO_LEVEL_BITS = 5;

  typedef logic [FIFO_PTR_BITS-1:0]   fifo_ptr_t;
  typedef logic [FIFO_LEVEL_BITS-1:0] fifo_level_t;
  typedef logic [FIFO_WIDTH-1:0]      fifo_data_t;

  typedef struct packed {
    fifo_ptr_t   wr_ptr;
    fifo_ptr_t   rd_ptr;
    fifo_level_t rf_count;
    logic        out_valid;
    fifo_data_t  out_data;
  } fifo_state_t;

endpackage

// File: rtl/fifo_ctl_16_4.sv
// Pointer/occupancy/handshake controller for a 16x4 register-file FIFO
// with one registered output stage (17 entries total).
module fifo_ctl_16_4
  import fifo_ctl_16_4_pkg::*;
#(
  parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
  input  logic                       fifo_clock,
  input  logic                       fifo_reset,
  input  logic                       fifo_flush,
  input  logic                       push_valid,
  input  logic [FIFO_WIDTH-1:0]      push_data,
  output logic                       push_ready,
  output logic                       pop_valid,
  output logic [FIFO_WIDTH-1:0]      pop_data,
  input  logic                       pop_ready,
  output logic [FIFO_LEVEL_BITS-1:0] fifo_level,
  output logic                       fifo_almost_full,
  output logic                       rf_wr_enable,
  output logic [FIFO_PTR_BITS-1:0]   rf_wr_addr,
  output logic [FIFO_WIDTH-1:0]      rf_wr_data,
  output logic [FIFO_PTR_BITS-1:0]   rf_rd_addr_0,
  input  logic [FIFO_WIDTH-1:0]      rf_rd_data_0
);

  localparam int unsigned LW = FIFO_LEVEL_BITS;
  localparam int unsigned PW = FIFO_PTR_BITS;

  fifo_state_t st_q;
  fifo_state_t st_d;

  logic push_fire;
  logic load;
  logic rf_has_data;
  logic bypass;
  logic rf_wr;
  logic rf_rd;

  // Handshake decode; flush suppresses every transfer in its cycle.
  always_comb begin
    rf_has_data = (st_q.rf_count != '0);
    push_fire   = push_valid & push_ready & ~fifo_flush;
    load        = (~st_q.out_valid | pop_ready) & ~fifo_flush;
    rf_rd       = load & rf_has_data;
    bypass      = load & ~rf_has_data & push_fire;
    rf_wr       = push_fire & ~bypass;
  end

  // Next-state: output stage loads from the rf first, then the bypass path.
  always_comb begin
    st_d = st_q;
    if (fifo_flush) begin
      st_d.wr_ptr    = '0;
      st_d.rd_ptr    = '0;
      st_d.rf_count  = '0;
      st_d.out_valid = 1'b0;
    end else begin
      if (load) begin
        if (rf_has_data) begin
          st_d.out_data  = rf_rd_data_0;
          st_d.out_valid = 1'b1;
          st_d.rd_ptr    = st_q.rd_ptr + PW'(1);
        end else if (push_fire) begin
          st_d.out_data  = push_data;
          st_d.out_valid = 1'b1;
        end else begin
          st_d.out_valid = 1'b0;
        end
      end
      if (rf_wr) begin
        st_d.wr_ptr = st_q.wr_ptr + PW'(1);
      end
      st_d.rf_count = st_q.rf_count + LW'(rf_wr) - LW'(rf_rd);
    end
  end

  always_ff @(posedge fifo_clock or negedge fifo_reset) begin
    if (!fifo_reset) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  // Ready depends only on registered occupancy, never on pop_ready.
  assign push_ready       = (st_q.rf_count != LW'(FIFO_DEPTH));
  assign pop_valid        = st_q.out_valid;
  assign pop_data         = st_q.out_data;
  assign fifo_level       = st_q.rf_count + LW'(st_q.out_valid);
  assign fifo_almost_full = (32'(fifo_level) >= ALMOST_FULL_LEVEL);

  assign rf_wr_enable = rf_wr;
  assign rf_wr_addr   = st_q.wr_ptr;
  assign rf_wr_data   = push_data;
  assign rf_rd_addr_0 = st_q.rd_ptr;

endmodule

// File: tb/tb_fifo_ctl_16_4.sv
// Scoreboard bench for fifo_ctl_16_4 with a behavioural 16x4 register file.
module tb_fifo_ctl_16_4;

  localparam int unsigned AF = 12;

  logic       fifo_clock;
  logic       fifo_reset;
  logic       fifo_flush;
  logic       push_valid;
  logic [3:0] push_data;
  logic       push_ready;
  logic       pop_valid;
  logic [3:0] pop_data;
  logic       pop_ready;
  logic [4:0] fifo_level;
  logic       fifo_almost_full;
  logic       rf_wr_enable;
  logic [3:0] rf_wr_addr;
  logic [3:0] rf_wr_data;
  logic [3:0] rf_rd_addr_0;
  logic [3:0] rf_rd_data_0;

  logic [3:0] rf_mem [16];
  logic [3:0] exp_q [$];
  int n_cmp;
  int n_err;

  fifo_ctl_16_4 #(.ALMOST_FULL_LEVEL(AF)) dut (
    .fifo_clock       (fifo_clock),
    .fifo_reset       (fifo_reset),
    .fifo_flush       (fifo_flush),
    .push_valid       (push_valid),
    .push_data        (push_data),
    .push_ready       (push_ready),
    .pop_valid        (pop_valid),
    .pop_data         (pop_data),
    .pop_ready        (pop_ready),
    .fifo_level       (fifo_level),
    .fifo_almost_full (fifo_almost_full),
    .rf_wr_enable     (rf_wr_enable),
    .rf_wr_addr       (rf_wr_addr),
    .rf_wr_data       (rf_wr_data),
    .rf_rd_addr_0     (rf_rd_addr_0),
    .rf_rd_data_0     (rf_rd_data_0)
  );

  initial fifo_clock = 1'b0;
  always #5 fifo_clock = ~fifo_clock;

  // Register-file macro model: synchronous write, combinational read.
  initial for (int i = 0; i < 16; i++) rf_mem[i] = 4'h0;
  always @(posedge fifo_clock) if (rf_wr_enable) rf_mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data_0 = rf_mem[rf_rd_addr_0];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check pre-edge outputs, update model after the edge.
  task automatic cycle(input logic pv, input logic [3:0] pd, input logic pr, input logic fl);
    int   sz;
    logic fire;
    logic pop;
    logic byp;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    fifo_flush = fl;
    #1;
    sz = exp_q.size();
    check("level", fifo_level, sz);
    check("push_ready", push_ready, sz < 17);
    check("pop_valid", pop_valid, sz > 0);
    check("almost_full", fifo_almost_full, sz >= AF);
    if (sz > 0) check("pop_data", pop_data, exp_q[0]);
    fire = pv && (sz < 17) && !fl;
    pop  = (sz > 0) && pr && !fl;
    byp  = fire && ((sz == 0) || ((sz == 1) && pr));
    check("rf_wr_enable", rf_wr_enable, fire && !byp);
    @(posedge fifo_clock);
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (fire) exp_q.push_back(pd);
    end
    @(negedge fifo_clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_push_ready"}, push_ready, 1);
    check({tag, "_pop_valid"}, pop_valid, 0);
    check({tag, "_pop_data"}, pop_data, 0);
    check({tag, "_almost_full"}, fifo_almost_full, 0);
    check({tag, "_rf_wr_enable"}, rf_wr_enable, 0);
  endtask

  initial begin
    logic [3:0] held;
    n_cmp = 0;
    n_err = 0;
    fifo_reset = 1'b1;
    fifo_flush = 1'b0;
    push_valid = 1'b0;
    push_data  = 4'h0;
    pop_ready  = 1'b0;
    #1 fifo_reset = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge fifo_clock);
    @(negedge fifo_clock);
    fifo_reset = 1'b1;

    // Single push into empty FIFO: bypass, visible next cycle.
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check("empty_hold_data", pop_data, 4'h3);

    // Fill to 17, then an extra push that must be held off.
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    check("full_level", fifo_level, 17);
    // Full with push and pop together: head leaves, push refused.
    cycle(1'b1, 4'h7, 1'b1, 1'b0);
    check("after_full_ready", push_ready, 1);
    check("after_full_level", fifo_level, 16);
    for (int i = 0; i < 17; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check("drained_level", fifo_level, 0);

    // Streaming at level 1, then at level 4 so the pointers wrap.
    for (int i = 0; i < 40; i++) cycle(1'b1, 4'(i + 5), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 10), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 4'(3 * i + 1), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Flush at level 9 with a push offered.
    for (int i = 0; i < 9; i++) cycle(1'b1, 4'(15 - i), 1'b0, 1'b0);
    held = pop_data;
    cycle(1'b1, 4'h6, 1'b0, 1'b1);
    check("flush_data_kept", pop_data, held);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 2), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges at level 5.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 8), 1'b0, 1'b0);
    push_valid = 1'b0;
    #2 fifo_reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge fifo_clock);
    fifo_reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 4), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
